// File: rtl/world_map_arbiter.sv
// ============================================================================
// world_map_arbiter
//   Shares the world-map read port between the video scan path and the cpu
//   lookup path, routing each returned pixel back to its owner via a tag pipe.
//   Optional starvation guard for the cpu path: define ARB_STARVE_GUARD_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module world_map_arbiter #(
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vid_req,
   input  logic [9:0] vid_row,
   input  logic [9:0] vid_col,
   output logic       vid_gnt,
   output logic       vid_rvalid,
   output logic [1:0] vid_pixel,
   input  logic       cpu_req,
   input  logic [9:0] cpu_row,
   input  logic [9:0] cpu_col,
   output logic       cpu_gnt,
   output logic       cpu_rvalid,
   output logic [1:0] cpu_pixel,
   output logic [9:0] map_row,
   output logic [9:0] map_col,
   input  logic [1:0] map_pixel,
   output logic       cpu_forced
);

   logic              force_cpu;
   logic              grant_any;
   logic [RD_LAT:0]   tag_valid;
   logic [RD_LAT:0]   tag_owner;   // 1 = cpu, 0 = video
   logic              ret_vid;
   logic              ret_cpu;

`ifdef ARB_STARVE_GUARD_EN
   localparam logic [7:0] STARVE_LIMIT = 8'(STARVE_MAX);

   logic [7:0] starve_cnt;

   assign force_cpu = reset & cpu_req & (starve_cnt == STARVE_LIMIT);

   // Counts only cycles where cpu is actually waiting; any withdrawal restarts the wait.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= 8'd0;
      end else if (!cpu_req || cpu_gnt) begin
         starve_cnt <= 8'd0;
      end else if (starve_cnt != STARVE_LIMIT) begin
         starve_cnt <= starve_cnt + 8'd1;
      end
   end
`else
   assign force_cpu = 1'b0;
`endif

   // Grants are gated by reset so nothing is accepted while the pipe is held clear.
   always_comb begin
      vid_gnt    = reset & vid_req & ~force_cpu;
      cpu_gnt    = reset & cpu_req & (~vid_req | force_cpu);
      cpu_forced = force_cpu;
   end

   assign grant_any = vid_gnt | cpu_gnt;
   assign ret_vid   = tag_valid[RD_LAT] & ~tag_owner[RD_LAT];
   assign ret_cpu   = tag_valid[RD_LAT] &  tag_owner[RD_LAT];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         map_row    <= 10'd0;
         map_col    <= 10'd0;
         tag_valid  <= '0;
         tag_owner  <= '0;
         vid_rvalid <= 1'b0;
         cpu_rvalid <= 1'b0;
         vid_pixel  <= 2'd0;
         cpu_pixel  <= 2'd0;
      end else begin
         if (grant_any) begin
            map_row <= cpu_gnt ? cpu_row : vid_row;
            map_col <= cpu_gnt ? cpu_col : vid_col;
         end
         // Stage k is visible k+1 cycles after the grant; the last stage lines up with map_pixel.
         tag_valid  <= {tag_valid[RD_LAT-1:0], grant_any};
         tag_owner  <= {tag_owner[RD_LAT-1:0], cpu_gnt};
         vid_rvalid <= ret_vid;
         cpu_rvalid <= ret_cpu;
         if (ret_vid) begin
            vid_pixel <= map_pixel;
         end
         if (ret_cpu) begin
            cpu_pixel <= map_pixel;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_world_map_arbiter.sv
// ============================================================================
// tb_world_map_arbiter
//   Directed bench for world_map_arbiter with a latency-accurate map model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_world_map_arbiter;

   localparam int LAT  = 3;
   localparam int SMAX = 15;
   localparam int NV   = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       vid_req, cpu_req;
   logic [9:0] vid_row, vid_col, cpu_row, cpu_col;
   logic       vid_gnt, cpu_gnt, vid_rvalid, cpu_rvalid, cpu_forced;
   logic [1:0] vid_pixel, cpu_pixel, map_pixel;
   logic [9:0] map_row, map_col;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   world_map_arbiter #(.RD_LAT(LAT), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .reset(reset),
      .vid_req(vid_req), .vid_row(vid_row), .vid_col(vid_col),
      .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid), .vid_pixel(vid_pixel),
      .cpu_req(cpu_req), .cpu_row(cpu_row), .cpu_col(cpu_col),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_pixel(cpu_pixel),
      .map_row(map_row), .map_col(map_col), .map_pixel(map_pixel),
      .cpu_forced(cpu_forced)
   );

   // Map contents: pixel = (row + 3*col + 1) mod 4, delivered LAT cycles after the address.
   function automatic logic [1:0] fpix(input logic [9:0] r, input logic [9:0] c);
      logic [11:0] s;
      s = 12'(r) + 12'(c) * 12'd3 + 12'd1;
      return s[1:0];
   endfunction

   logic [1:0] mp_pipe [LAT];
   initial for (int i = 0; i < LAT; i++) mp_pipe[i] = 2'd0;
   always @(posedge clk) begin
      mp_pipe[0] <= fpix(map_row, map_col);
      for (int i = 1; i < LAT; i++) mp_pipe[i] <= mp_pipe[i-1];
   end
   assign map_pixel = mp_pipe[LAT-1];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic single_read(input bit is_cpu, input logic [9:0] r, input logic [9:0] c,
                              input logic [1:0] exp_pix, input logic [1:0] exp_other);
      @(posedge clk); #1;
      if (is_cpu) begin cpu_req = 1'b1; cpu_row = r; cpu_col = c; end
      else        begin vid_req = 1'b1; vid_row = r; vid_col = c; end
      @(negedge clk);
      check("gnt_owner", 32'(is_cpu ? cpu_gnt : vid_gnt), 32'd1);
      check("gnt_other", 32'(is_cpu ? vid_gnt : cpu_gnt), 32'd0);
      @(posedge clk); #1;
      vid_req = 1'b0; cpu_req = 1'b0;
      @(negedge clk);
      check("map_row", 32'(map_row), 32'(r));
      check("map_col", 32'(map_col), 32'(c));
      for (int k = 2; k <= LAT + 3; k++) begin
         @(posedge clk); @(negedge clk);
         check("rvalid_owner", 32'(is_cpu ? cpu_rvalid : vid_rvalid), 32'(k == LAT + 2));
         check("rvalid_other", 32'(is_cpu ? vid_rvalid : cpu_rvalid), 32'd0);
         if (k == LAT + 2) begin
            check("pix_owner", 32'(is_cpu ? cpu_pixel : vid_pixel), 32'(exp_pix));
            check("pix_other", 32'(is_cpu ? vid_pixel : cpu_pixel), 32'(exp_other));
         end
      end
   endtask

   task automatic idle(input int n);
      @(posedge clk); #1;
      vid_req = 1'b0; cpu_req = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   initial begin
      reset   = 1'b0;
      vid_req = 1'b1; cpu_req = 1'b1;
      vid_row = 10'd3; vid_col = 10'd4; cpu_row = 10'd6; cpu_col = 10'd8;

      // Reset state, with requests asserted to show grants stay low.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_map_row", 32'(map_row), 32'd0);
      check("rst_map_col", 32'(map_col), 32'd0);
      check("rst_vid_gnt", 32'(vid_gnt), 32'd0);
      check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      check("rst_vid_rvalid", 32'(vid_rvalid), 32'd0);
      check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      check("rst_vid_pixel", 32'(vid_pixel), 32'd0);
      check("rst_cpu_pixel", 32'(cpu_pixel), 32'd0);
      check("rst_cpu_forced", 32'(cpu_forced), 32'd0);
      vid_req = 1'b0; cpu_req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);

      // Single reads: (5,9) -> 5+27+1=33 -> 1 ; (7,2) -> 7+6+1=14 -> 2.
      single_read(1'b0, 10'd5, 10'd9, 2'd1, 2'd0);
      single_read(1'b1, 10'd7, 10'd2, 2'd2, 2'd1);

      // Contention with both requests held.
      @(posedge clk); #1;
      vid_req = 1'b1; vid_row = 10'd100; vid_col = 10'd200;
      cpu_req = 1'b1; cpu_row = 10'd300; cpu_col = 10'd400;
`ifdef ARB_STARVE_GUARD_EN
      for (int c = 0; c < 2 * (SMAX + 1); c++) begin
         if (c > 0) @(posedge clk);
         @(negedge clk);
         check("cont_cpu_gnt", 32'(cpu_gnt), 32'((c % (SMAX + 1)) == SMAX));
         check("cont_vid_gnt", 32'(vid_gnt), 32'((c % (SMAX + 1)) != SMAX));
         check("cont_forced", 32'(cpu_forced), 32'((c % (SMAX + 1)) == SMAX));
      end
`else
      for (int c = 0; c < 100; c++) begin
         if (c > 0) @(posedge clk);
         @(negedge clk);
         check("cont_cpu_gnt", 32'(cpu_gnt), 32'd0);
         check("cont_vid_gnt", 32'(vid_gnt), 32'd1);
         check("cont_forced", 32'(cpu_forced), 32'd0);
      end
`endif
      idle(LAT + 4);

      // Withdrawal: cpu waits 4 cycles, drops out, and must never see a return.
      @(posedge clk); #1;
      vid_req = 1'b1; cpu_req = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(posedge clk);
         @(negedge clk);
         check("wd_cpu_gnt", 32'(cpu_gnt), 32'd0);
      end
      @(posedge clk); #1;
      cpu_req = 1'b0;
      for (int c = 0; c < LAT + 4; c++) begin
         @(negedge clk);
         check("wd_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
         @(posedge clk);
      end
`ifdef ARB_STARVE_GUARD_EN
      #1;
      cpu_req = 1'b1;
      for (int c = 0; c <= SMAX; c++) begin
         if (c > 0) @(posedge clk);
         @(negedge clk);
         check("wd_rewait_gnt", 32'(cpu_gnt), 32'(c == SMAX));
      end
`endif
      idle(LAT + 4);

      // Interleaved streaming: vid on even cycles, cpu on odd, distinct addresses.
      for (int c = 0; c < NV + LAT + 4; c++) begin
         int g;
         logic ev, ec;
         @(posedge clk); #1;
         if (c < NV) begin
            vid_req = (c % 2 == 0); cpu_req = (c % 2 == 1);
            vid_row = 10'(20 + c); vid_col = 10'(40 + 5 * c);
            cpu_row = 10'(20 + c); cpu_col = 10'(40 + 5 * c);
         end else begin
            vid_req = 1'b0; cpu_req = 1'b0;
         end
         @(negedge clk);
         if (c < NV) begin
            check("il_vid_gnt", 32'(vid_gnt), 32'(c % 2 == 0));
            check("il_cpu_gnt", 32'(cpu_gnt), 32'(c % 2 == 1));
         end
         g  = c - LAT - 2;
         ev = (g >= 0) && (g < NV) && (g % 2 == 0);
         ec = (g >= 0) && (g < NV) && (g % 2 == 1);
         check("il_vid_rvalid", 32'(vid_rvalid), 32'(ev));
         check("il_cpu_rvalid", 32'(cpu_rvalid), 32'(ec));
         if (ev) check("il_vid_pixel", 32'(vid_pixel), 32'(fpix(10'(20 + g), 10'(40 + 5 * g))));
         if (ec) check("il_cpu_pixel", 32'(cpu_pixel), 32'(fpix(10'(20 + g), 10'(40 + 5 * g))));
      end

      // Reset with two reads in flight: outputs clear at once, no stale returns.
      @(posedge clk); #1;
      vid_req = 1'b1; vid_row = 10'd11; vid_col = 10'd13;
      @(posedge clk); #1;
      vid_row = 10'd12; vid_col = 10'd14;
      @(posedge clk); #1;
      vid_req = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("mrst_map_row", 32'(map_row), 32'd0);
      check("mrst_map_col", 32'(map_col), 32'd0);
      check("mrst_vid_pixel", 32'(vid_pixel), 32'd0);
      check("mrst_cpu_pixel", 32'(cpu_pixel), 32'd0);
      check("mrst_vid_rvalid", 32'(vid_rvalid), 32'd0);
      check("mrst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      for (int c = 0; c < LAT + 5; c++) begin
         @(negedge clk);
         check("mrst_no_vid_ret", 32'(vid_rvalid), 32'd0);
         check("mrst_no_cpu_ret", 32'(cpu_rvalid), 32'd0);
         @(posedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
